// File: rtl/pipeline_hazard.sv
// Hazard unit for a five-stage pipeline: operand bypass selects, load-use stall,
// branch flush, and a multi-cycle ALU wait state with timeout and stall accounting.
module pipeline_hazard #(
    parameter int unsigned MUL_TIMEOUT = 34,
    parameter int unsigned CNT_WIDTH   = 16
) (
    input  logic                 clk,
    input  logic                 n_rst,
    input  logic [4:0]           Rs1D,
    input  logic [4:0]           Rs2D,
    input  logic [4:0]           Rs1E,
    input  logic [4:0]           Rs2E,
    input  logic [4:0]           RdE,
    input  logic [4:0]           RdM,
    input  logic [4:0]           RdW,
    input  logic                 RegWriteM,
    input  logic                 RegWriteW,
    input  logic [1:0]           ResultSrcE,
    input  logic [1:0]           PCSrcE,
    input  logic                 mul_startE,
    input  logic                 mul_doneE,
    output logic                 StallF,
    output logic                 StallD,
    output logic                 StallE,
    output logic                 FlushD,
    output logic                 FlushE,
    output logic [1:0]           ForwardAE,
    output logic [1:0]           ForwardBE,
    output logic [CNT_WIDTH-1:0] stall_cycles,
    output logic                 err_timeout
);

    localparam int unsigned WAIT_W = $clog2(MUL_TIMEOUT + 1);

    typedef enum logic {RUN, MULWAIT} state_t;

    state_t            state;
    state_t            nextState;
    logic [WAIT_W-1:0] waitCnt;
    logic [WAIT_W-1:0] waitCntNext;
    logic              lwStall;
    logic              timeoutHit;

    // Bypass selects: memory stage wins over writeback; x0 is never forwarded.
    always_comb begin
        ForwardAE = 2'b00;
        if (RegWriteM && (RdM != 5'd0) && (RdM == Rs1E)) begin
            ForwardAE = 2'b10;
        end else if (RegWriteW && (RdW != 5'd0) && (RdW == Rs1E)) begin
            ForwardAE = 2'b01;
        end
    end

    always_comb begin
        ForwardBE = 2'b00;
        if (RegWriteM && (RdM != 5'd0) && (RdM == Rs2E)) begin
            ForwardBE = 2'b10;
        end else if (RegWriteW && (RdW != 5'd0) && (RdW == Rs2E)) begin
            ForwardBE = 2'b01;
        end
    end

    assign lwStall = (ResultSrcE == 2'b01) && (RdE != 5'd0) &&
                     ((RdE == Rs1D) || (RdE == Rs2D));

    // Next state and stall/flush controls; redirect beats multi-cycle start beats load-use.
    always_comb begin
        nextState   = state;
        waitCntNext = waitCnt;
        StallF      = 1'b0;
        StallD      = 1'b0;
        StallE      = 1'b0;
        FlushD      = 1'b0;
        FlushE      = 1'b0;
        timeoutHit  = 1'b0;
        unique case (state)
            RUN: begin
                if (PCSrcE != 2'b00) begin
                    FlushD = 1'b1;
                    FlushE = 1'b1;
                end else if (mul_startE && !mul_doneE) begin
                    StallF      = 1'b1;
                    StallD      = 1'b1;
                    StallE      = 1'b1;
                    nextState   = MULWAIT;
                    waitCntNext = WAIT_W'(1);
                end else if (mul_startE && mul_doneE) begin
                    nextState = RUN;
                end else if (lwStall) begin
                    StallF = 1'b1;
                    StallD = 1'b1;
                    FlushE = 1'b1;
                end
            end
            MULWAIT: begin
                if (mul_doneE) begin
                    nextState   = RUN;
                    waitCntNext = '0;
                end else if (waitCnt == WAIT_W'(MUL_TIMEOUT)) begin
                    nextState   = RUN;
                    waitCntNext = '0;
                    timeoutHit  = 1'b1;
                end else begin
                    StallF      = 1'b1;
                    StallD      = 1'b1;
                    StallE      = 1'b1;
                    waitCntNext = waitCnt + WAIT_W'(1);
                end
            end
            default: begin
                nextState   = RUN;
                waitCntNext = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state   <= RUN;
            waitCnt <= '0;
        end else begin
            state   <= nextState;
            waitCnt <= waitCntNext;
        end
    end

    // Stall performance counter saturates at all-ones.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            stall_cycles <= '0;
        end else if (StallF && (stall_cycles != '1)) begin
            stall_cycles <= stall_cycles + CNT_WIDTH'(1);
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            err_timeout <= 1'b0;
        end else if (timeoutHit) begin
            err_timeout <= 1'b1;
        end
    end

endmodule

// File: tb/tb_pipeline_hazard.sv
// Scoreboard bench for pipeline_hazard: the driver queues expected outputs per cycle,
// a negedge monitor pops and compares them against the DUT.
module tb_pipeline_hazard;

    localparam int unsigned CW = 6;

    logic          clk;
    logic          n_rst;
    logic [4:0]    Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW;
    logic          RegWriteM, RegWriteW;
    logic [1:0]    ResultSrcE, PCSrcE;
    logic          mul_startE, mul_doneE;
    logic          StallF, StallD, StallE, FlushD, FlushE;
    logic [1:0]    ForwardAE, ForwardBE;
    logic [CW-1:0] stall_cycles;
    logic          err_timeout;

    pipeline_hazard #(.MUL_TIMEOUT(34), .CNT_WIDTH(CW)) dut (
        .clk(clk), .n_rst(n_rst),
        .Rs1D(Rs1D), .Rs2D(Rs2D), .Rs1E(Rs1E), .Rs2E(Rs2E), .RdE(RdE),
        .RdM(RdM), .RdW(RdW), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
        .ResultSrcE(ResultSrcE), .PCSrcE(PCSrcE),
        .mul_startE(mul_startE), .mul_doneE(mul_doneE),
        .StallF(StallF), .StallD(StallD), .StallE(StallE),
        .FlushD(FlushD), .FlushE(FlushE),
        .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
        .stall_cycles(stall_cycles), .err_timeout(err_timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [15:0]   expQ[$];
    string         nameQ[$];
    int            passCnt = 0;
    int            totalCnt = 0;
    logic [CW-1:0] mCnt;
    logic          mErr;

    // Monitor: compare {stalls, flushes, fwdA, fwdB, stall_cycles, err} once per cycle.
    always @(negedge clk) begin
        logic [15:0] e;
        logic [15:0] act;
        string       nm;
        if (expQ.size() > 0) begin
            e   = expQ.pop_front();
            nm  = nameQ.pop_front();
            act = {StallF, StallD, StallE, FlushD, FlushE, ForwardAE, ForwardBE,
                   stall_cycles, err_timeout};
            totalCnt++;
            if (act === e) passCnt++;
            else $display("FAIL %s: got %h expected %h", nm, act, e);
        end
    end

    task automatic clr();
        Rs1D = 0; Rs2D = 0; Rs1E = 0; Rs2E = 0; RdE = 0; RdM = 0; RdW = 0;
        RegWriteM = 0; RegWriteW = 0; ResultSrcE = 0; PCSrcE = 0;
        mul_startE = 0; mul_doneE = 0;
    endtask

    // Queue expectation for the current cycle, then advance one clock.
    task automatic chk(input string nm, input logic [2:0] s, input logic [1:0] f,
                       input logic [1:0] a, input logic [1:0] b);
        expQ.push_back({s, f, a, b, mCnt, mErr});
        nameQ.push_back(nm);
        @(posedge clk);
        if (s[2] && n_rst && (mCnt != '1)) mCnt = mCnt + CW'(1);
        #1;
    endtask

    task automatic runTimeout(input string tag);
        clr(); mul_startE = 1;
        chk({tag, "_start"}, 3'b111, 2'b00, 2'b00, 2'b00);
        clr();
        for (int i = 0; i < 33; i++) chk({tag, "_wait"}, 3'b111, 2'b00, 2'b00, 2'b00);
        chk({tag, "_exit"}, 3'b000, 2'b00, 2'b00, 2'b00);
        mErr = 1'b1;
    endtask

    initial begin
        clr();
        n_rst = 1'b0; mCnt = '0; mErr = 1'b0;
        @(posedge clk); #1;
        chk("reset", 3'b000, 2'b00, 2'b00, 2'b00);
        n_rst = 1'b1;

        clr(); RdM = 5; RegWriteM = 1; RdW = 5; RegWriteW = 1; Rs1E = 5;
        chk("fwd_mem_prio", 3'b000, 2'b00, 2'b10, 2'b00);
        RdM = 0;
        chk("fwd_wb", 3'b000, 2'b00, 2'b01, 2'b00);
        clr(); Rs1E = 3; Rs2E = 5; RdM = 5; RegWriteM = 1; RdW = 3; RegWriteW = 1;
        chk("fwd_both", 3'b000, 2'b00, 2'b01, 2'b10);
        clr(); Rs1E = 5; RdM = 5; RdW = 9; RegWriteW = 1;
        chk("fwd_nowrite", 3'b000, 2'b00, 2'b00, 2'b00);
        clr(); RegWriteM = 1; RegWriteW = 1;
        chk("fwd_x0", 3'b000, 2'b00, 2'b00, 2'b00);

        clr(); ResultSrcE = 2'b01; RdE = 7; Rs2D = 7;
        chk("lw_stall", 3'b110, 2'b01, 2'b00, 2'b00);
        clr();
        chk("lw_after", 3'b000, 2'b00, 2'b00, 2'b00);
        ResultSrcE = 2'b01; RdE = 0; Rs1D = 0;
        chk("lw_x0", 3'b000, 2'b00, 2'b00, 2'b00);
        clr(); ResultSrcE = 2'b00; RdE = 7; Rs1D = 7;
        chk("nonload", 3'b000, 2'b00, 2'b00, 2'b00);

        clr(); PCSrcE = 2'b01; ResultSrcE = 2'b01; RdE = 7; Rs1D = 7; mul_startE = 1;
        chk("redirect", 3'b000, 2'b11, 2'b00, 2'b00);
        clr();
        chk("redirect_after", 3'b000, 2'b00, 2'b00, 2'b00);

        mul_startE = 1; mul_doneE = 1;
        chk("mul_single", 3'b000, 2'b00, 2'b00, 2'b00);
        clr();
        chk("mul_single_after", 3'b000, 2'b00, 2'b00, 2'b00);

        mul_startE = 1;
        chk("mul_start", 3'b111, 2'b00, 2'b00, 2'b00);
        clr();
        chk("mul_wait", 3'b111, 2'b00, 2'b00, 2'b00);
        PCSrcE = 2'b01; ResultSrcE = 2'b01; RdE = 7; Rs1D = 7;
        chk("wait_ignore", 3'b111, 2'b00, 2'b00, 2'b00);
        clr();
        chk("mul_wait", 3'b111, 2'b00, 2'b00, 2'b00);
        chk("mul_wait", 3'b111, 2'b00, 2'b00, 2'b00);
        mul_doneE = 1;
        chk("mul_done", 3'b000, 2'b00, 2'b00, 2'b00);
        clr();
        chk("mul_after", 3'b000, 2'b00, 2'b00, 2'b00);

        runTimeout("to");
        clr();
        chk("to_err", 3'b000, 2'b00, 2'b00, 2'b00);
        chk("err_sticky", 3'b000, 2'b00, 2'b00, 2'b00);

        runTimeout("sat");
        clr();
        chk("sat_hold", 3'b000, 2'b00, 2'b00, 2'b00);
        ResultSrcE = 2'b01; RdE = 4; Rs1D = 4;
        chk("sat_lw", 3'b110, 2'b01, 2'b00, 2'b00);
        clr();
        chk("sat_after", 3'b000, 2'b00, 2'b00, 2'b00);

        mul_startE = 1;
        chk("mr_start", 3'b111, 2'b00, 2'b00, 2'b00);
        clr();
        chk("mr_wait", 3'b111, 2'b00, 2'b00, 2'b00);
        #2 n_rst = 1'b0; mCnt = '0; mErr = 1'b0;
        chk("mid_reset", 3'b000, 2'b00, 2'b00, 2'b00);
        n_rst = 1'b1;
        chk("post_reset", 3'b000, 2'b00, 2'b00, 2'b00);
        ResultSrcE = 2'b01; RdE = 9; Rs2D = 9;
        chk("post_reset_lw", 3'b110, 2'b01, 2'b00, 2'b00);
        clr();
        chk("post_reset_idle", 3'b000, 2'b00, 2'b00, 2'b00);

        @(negedge clk); @(negedge clk);
        if (expQ.size() != 0) begin
            totalCnt++;
            $display("FAIL drain: got %0d pending expected 0", expQ.size());
        end
        $display("%0d/%0d checks passed", passCnt, totalCnt);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
